// File: rtl/uart_tx_scheduler.sv
// Pops words from a FIFO and hands them one at a time to a UART transmitter, with a completion timeout.
// Optional clear-to-send gating is compiled in when UART_TX_FLOW_CTRL_EN is defined (adds input cts_n).
module uart_tx_scheduler #(
    parameter int B       = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic         clk,
    input  logic         reset,
`ifdef UART_TX_FLOW_CTRL_EN
    input  logic         cts_n,
`endif
    input  logic         enable,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic         tx_start,
    output logic [B-1:0] tx_din,
    input  logic         tx_done_tick,
    output logic         busy,
    output logic [15:0]  tx_count,
    output logic         timeout_err,
    input  logic         clr_err
);

    // state  | meaning
    // S_IDLE | waiting for enable and a non-empty FIFO
    // S_LOAD | one cycle: pop FIFO and pulse tx_start
    // S_WAIT | waiting for tx_done_tick, bounded by the timeout timer
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [B-1:0]   din_q, din_d;
    logic [15:0]    count_q, count_d;
    logic           err_q, err_d;
    logic           fifo_rd_q, tx_start_q, busy_q;
    logic           start_ok;

`ifdef UART_TX_FLOW_CTRL_EN
    assign start_ok = enable & ~fifo_empty & ~cts_n;
`else
    assign start_ok = enable & ~fifo_empty;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        din_d   = din_q;
        count_d = count_q;
        err_d   = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                    din_d   = fifo_r_data;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                timer_d = 16'd0;
            end
            S_WAIT: begin
                // completion takes priority over a coincident expiry
                if (tx_done_tick) begin
                    state_d = S_IDLE;
                    count_d = count_q + 16'd1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // strobes are registered copies of the next-state decode, so they track state_q exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            din_q      <= '0;
            count_q    <= 16'd0;
            err_q      <= 1'b0;
            fifo_rd_q  <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            din_q      <= din_d;
            count_q    <= count_d;
            err_q      <= err_d;
            fifo_rd_q  <= (state_d == S_LOAD);
            tx_start_q <= (state_d == S_LOAD);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign fifo_rd     = fifo_rd_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign tx_din      = din_q;
    assign tx_count    = count_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a queue-backed FIFO and hand-computed expectations.
module tb_uart_tx_scheduler;
    localparam int B  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [B-1:0] fifo_r_data = '0;
    logic         tx_done_tick = 1'b0;
    logic         clr_err = 1'b0;
`ifdef UART_TX_FLOW_CTRL_EN
    logic         cts_n = 1'b0;
`endif
    logic         fifo_rd, tx_start, busy, timeout_err;
    logic [B-1:0] tx_din;
    logic [15:0]  tx_count;

    int           total = 0;
    int           bad = 0;
    int           n_rd = 0;
    int           n_start = 0;
    int           start0, rd0;
    logic         prev_start = 1'b0;
    logic         busy_seen;
    logic [B-1:0] sent[$];
    logic [B-1:0] q[$];

    uart_tx_scheduler #(.B(B), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef UART_TX_FLOW_CTRL_EN
        .cts_n        (cts_n),
`endif
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (fifo_rd),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .tx_count     (tx_count),
        .timeout_err  (timeout_err),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [B-1:0] w);
        q.push_back(w);
        fifo_empty  = 1'b0;
        fifo_r_data = q[0];
    endtask

    // one clock: sample just after the edge, log strobes, and pop on fifo_rd
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tx_start) begin
            chk("start_single", {31'b0, prev_start}, 32'd0);
            n_start++;
            sent.push_back(tx_din);
        end
        prev_start = tx_start;
        if (fifo_rd) begin
            n_rd++;
            if (q.size() > 0) void'(q.pop_front());
            fifo_empty  = (q.size() == 0);
            fifo_r_data = fifo_empty ? '0 : q[0];
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!tx_start && n < 100) begin
            cyc();
            n++;
        end
        chk("start_seen", {31'b0, tx_start}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_cnt", tx_count, 0);
        chk("rst_err", timeout_err, 0);
        reset = 1'b1;
        cyc();

        // single-word latency
        push(8'hA5);
        enable = 1'b1;
        cyc();
        chk("lat_start", tx_start, 1);
        chk("lat_rd", fifo_rd, 1);
        chk("lat_din", tx_din, 8'hA5);
        chk("lat_busy", busy, 1);
        cyc();
        chk("load1_start", tx_start, 0);
        chk("load1_rd", fifo_rd, 0);
        chk("wait_busy", busy, 1);
        chk("wait_din_hold", tx_din, 8'hA5);
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("done_busy", busy, 0);
        chk("done_cnt", tx_count, 1);

        // three words back to back
        reset = 1'b0;
        #1;
        chk("rst_cnt_clear", tx_count, 0);
        cyc();
        reset = 1'b1;
        n_rd = 0; n_start = 0; sent.delete();
        push(8'h07); push(8'h08); push(8'h06);
        for (int i = 0; i < 3; i++) begin
            wait_start();
            repeat (9) cyc();
            tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
            chk("b2b_gap", tx_start, 0);
            if (i < 2) begin
                cyc();
                chk("b2b_start", tx_start, 1);
            end
        end
        chk("seq_len", sent.size(), 3);
        chk("seq0", sent[0], 8'h07);
        chk("seq1", sent[1], 8'h08);
        chk("seq2", sent[2], 8'h06);
        chk("seq_rd", n_rd, 3);
        chk("seq_cnt", tx_count, 3);
        cyc();
        chk("seq_idle", busy, 0);

        // timeout: 16 cycles in WAIT
        push(8'h3C);
        wait_start();
        cyc();
        chk("to_wait", busy, 1);
        repeat (15) cyc();
        chk("to_before_busy", busy, 1);
        chk("to_before_err", timeout_err, 0);
        cyc();
        chk("to_exit_busy", busy, 0);
        chk("to_err", timeout_err, 1);
        chk("to_cnt", tx_count, 3);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("clr_err", timeout_err, 0);

        // timeout set beats simultaneous clear
        push(8'h4D);
        wait_start();
        cyc();
        repeat (15) cyc();
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("set_wins", timeout_err, 1);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("clr_again", timeout_err, 0);

        // done coincident with expiry counts as completion
        push(8'h5E);
        wait_start();
        cyc();
        repeat (15) cyc();
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("sim_err", timeout_err, 0);
        chk("sim_cnt", tx_count, 4);
        chk("sim_busy", busy, 0);

        // done outside WAIT is ignored
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("idle_done_cnt", tx_count, 4);
        push(8'h6F);
        wait_start();
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("load_done_busy", busy, 1);
        chk("load_done_cnt", tx_count, 4);
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("load_done_fin", tx_count, 5);

        // enable low holds off transfers
        enable = 1'b0;
        push(8'h5A);
        start0 = n_start; rd0 = n_rd; busy_seen = 1'b0;
        repeat (50) begin
            cyc();
            if (busy) busy_seen = 1'b1;
        end
        chk("en0_start", n_start - start0, 0);
        chk("en0_rd", n_rd - rd0, 0);
        chk("en0_busy", busy_seen, 0);
        enable = 1'b1;
        cyc();
        chk("en1_start", tx_start, 1);
        chk("en1_din", tx_din, 8'h5A);

        // enable dropped mid-transfer
        enable = 1'b0;
        push(8'h77);
        cyc();
        chk("endrop_busy", busy, 1);
        repeat (3) cyc();
        tx_done_tick = 1'b1; cyc(); tx_done_tick = 1'b0;
        chk("endrop_cnt", tx_count, 6);
        chk("endrop_idle", busy, 0);
        start0 = n_start;
        repeat (5) cyc();
        chk("endrop_nostart", n_start - start0, 0);

        // reset during WAIT
        enable = 1'b1;
        wait_start();
        chk("pre_rst_din", tx_din, 8'h77);
        push(8'h99);
        cyc();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", tx_start, 0);
        chk("arst_rd", fifo_rd, 0);
        chk("arst_din", tx_din, 0);
        chk("arst_cnt", tx_count, 0);
        chk("arst_err", timeout_err, 0);
        cyc(); cyc();
        reset = 1'b1;
        wait_start();
        chk("resume_din", tx_din, 8'h99);
        tx_done_tick = 1'b1; cyc(); cyc(); tx_done_tick = 1'b0;
        chk("resume_cnt", tx_count, 1);

`ifdef UART_TX_FLOW_CTRL_EN
        // clear-to-send gating
        cts_n = 1'b1;
        push(8'hC3);
        start0 = n_start;
        repeat (10) cyc();
        chk("cts_hold", n_start - start0, 0);
        cts_n = 1'b0;
        cyc();
        if (!tx_start) cyc();
        chk("cts_start", tx_start, 1);
        chk("cts_din", tx_din, 8'hC3);
        tx_done_tick = 1'b1; cyc(); cyc(); tx_done_tick = 1'b0;
        chk("cts_cnt", tx_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
